dmem_access_seq: RTL and testbench
==================================

// Module: dmem_access_seq
// PURPOSE
//  Sequences every data-memory access issued by the MEM stage (MemRead/MemWrite from the main decoder).
//  Handles a variable-latency memory port with a req/ack handshake; stalls the pipeline until the access completes.
//  Generates byte-lane write masks and sign/zero-extends load data per Funct3.
//  Flags misaligned or illegal accesses and memory timeouts. Sits between the MEM stage and the data memory.
// PARAMETERS
//  ADDR_W   9   byte-address width
//  DATA_W   32  data width; fixed at 32 (4 byte lanes)
//  TIMEOUT  15  max cycles spent in WAIT before the access is abandoned
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  reset      in   1       synchronous, active-high
//  MemRead    in   1       load in MEM stage
//  MemWrite   in   1       store in MEM stage
//  Funct3     in   3       000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
//  addr       in   ADDR_W  byte address from ALU
//  wdata      in   DATA_W  store data (rs2)
//  mem_req    out  1       request valid to memory
//  mem_we     out  1       1 = write
//  mem_addr   out  ADDR_W  word-aligned address (addr[1:0] = 2'b00)
//  mem_wdata  out  DATA_W  store data replicated into lanes
//  mem_wmask  out  4       byte-lane enables
//  mem_ack    in   1       memory completed the request (read data valid the same cycle)
//  mem_rdata  in   DATA_W  raw word read
//  stall      out  1       hold IF/ID/EX/MEM stages
//  rd_data    out  DATA_W  extended load result; valid in DONE
//  fault      out  1       1-cycle pulse: misaligned access or illegal Funct3
//  timeout    out  1       1-cycle pulse: TIMEOUT reached
// BEHAVIOUR
//  Reset: state IDLE, cycle counter 0; every registered output 0; stall forced to 0 while reset = 1.
//  FSM states: IDLE, REQ, WAIT, DONE.
//  IDLE: an access is MemRead or MemWrite. If MemRead and MemWrite are both 1, the access is treated as a store.
//   Legal access: latch addr, Funct3, wdata and we; stall = 1 combinationally in the same cycle; go to REQ.
//   Illegal access (lh/lhu/sh with addr[0] = 1; lw/sw with addr[1:0] != 0; Funct3 in {011, 110, 111}):
//    no mem_req; fault = 1 for one cycle; stall = 0; rd_data = 0; remain in IDLE.
//   mem_ack received in IDLE is ignored.
//  REQ: mem_req = 1 with the latched fields; stall = 1. mem_ack = 1 -> capture extended data, go to DONE; otherwise go to WAIT.
//  WAIT: mem_req stays 1 and all request fields stay stable; stall = 1; counter increments each cycle.
//   mem_ack = 1 -> go to DONE.
//   counter == TIMEOUT -> drop mem_req, timeout = 1, rd_data = 0, go to DONE.
//   If mem_ack and the timeout coincide in the same cycle, ack wins and no timeout pulse is produced.
//  DONE: stall = 0 and rd_data valid for exactly 1 cycle, then go to IDLE.
//   DONE never re-triggers, even though MemRead/MemWrite are still high this cycle.
//  Minimum latency: access seen at cycle T; stall = 1 in T and T+1; rd_data valid and stall = 0 at T+2.
//  Write mask: sb = 4'b0001 << addr[1:0]; sh = 4'b0011 << addr[1:0]; sw = 4'b1111.
//  Store data lanes: sb replicates wdata[7:0] x4; sh replicates wdata[15:0] x2.
//  Load extraction: select the byte/halfword lane given by the latched addr[1:0].
//   lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passes the word through.
//  Reset mid-access: return to IDLE at the next edge; mem_req drops; the in-flight ack is ignored.
//  Counter width is $clog2(TIMEOUT+1); the counter clears on entry to REQ.
// STRUCTURE
//  Package dmem_pkg: state_t enum; Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
//  Sub-module lsu_align (combinational): inputs Funct3, addr[1:0], wdata, mem_rdata;
//   outputs wmask, lane data, extended load data, illegal flag.
//  Top level: FSM, latches, counter.
// TESTING
//  lw addr 0x010, ack in REQ, rdata 0xDEADBEEF -> stall 2 cycles; rd_data 0xDEADBEEF at T+2.
//  lb addr 0x013, rdata 0x80FFFFFF -> mem_addr 0x010; rd_data 0xFFFFFF80.
//  lbu at the same address -> rd_data 0x00000080.
//  sh addr 0x006, wdata 0x1234ABCD -> mem_we 1; mem_wmask 4'b1100; mem_wdata 0xABCDABCD.
//  lw addr 0x002 -> fault pulse; mem_req never asserted; stall 0.
//  Funct3 3'b011 load -> fault pulse; no request issued.
//  sw with ack held low -> timeout pulse after 15 WAIT cycles; mem_req drops; stall 0 in DONE.
//  sw with ack and counter == TIMEOUT in the same cycle -> ack wins; no timeout pulse.
//  reset asserted during WAIT -> next cycle: IDLE, mem_req 0, stall 0; a late ack is ignored.

Source files
------------

// File: rtl/dmem_access_seq_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//   Shared types and constants for the data-memory access sequencer.
//   - state_t : sequencer FSM states
//   - F3_*    : Funct3 encodings of the supported load/store widths
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;  // lb / sb
  localparam logic [2:0] F3_H  = 3'b001;  // lh / sh
  localparam logic [2:0] F3_W  = 3'b010;  // lw / sw
  localparam logic [2:0] F3_BU = 3'b100;  // lbu
  localparam logic [2:0] F3_HU = 3'b101;  // lhu

endpackage

// File: rtl/dmem_access_seq_if.sv
// ---------------------------------------------------------------------------
// dmem_access_seq_if
//   Request/acknowledge bus between the access sequencer and data memory.
//   master (sequencer): drives mem_req, mem_we, mem_addr, mem_wdata, mem_wmask;
//                       receives mem_ack, mem_rdata.
//   slave  (memory)   : the mirror image.
//   Read data is valid in the same cycle as mem_ack.
// ---------------------------------------------------------------------------
interface dmem_access_seq_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_seq_lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align  (purely combinational)
//   Byte-lane handling for one access.
//   in  funct3    : access width / signedness
//   in  addr_lo   : byte offset within the word
//   in  wdata     : raw store data
//   in  rdata     : raw word returned by memory
//   out wmask     : byte-lane write enables
//   out lane_data : store data replicated across lanes
//   out load_data : selected lane, sign- or zero-extended
//   out illegal   : misaligned access or unsupported funct3
// ---------------------------------------------------------------------------
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] lane_data,
  output logic [31:0] load_data,
  output logic        illegal
);
  logic [7:0]  rbyte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rbyte[addr_lo];
  // Halfwords are only legal at offsets 0 and 2, so addr_lo[1] picks the half.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wmask     = 4'b0000;
    lane_data = '0;
    load_data = '0;
    illegal   = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        wmask     = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
        load_data = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'b0, byte_sel};
      end
      F3_H, F3_HU: begin
        wmask     = 4'b0011 << addr_lo;
        lane_data = {2{wdata[15:0]}};
        load_data = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                     : {16'b0, half_sel};
        illegal   = addr_lo[0];
      end
      F3_W: begin
        wmask     = 4'b1111;
        lane_data = wdata;
        load_data = rdata;
        illegal   = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/dmem_access_seq.sv
// ---------------------------------------------------------------------------
// dmem_access_seq
//   Sequences MEM-stage loads/stores onto a variable-latency req/ack memory
//   port and stalls the pipeline until each access completes.
//   clk, reset          : clock, synchronous active-high reset
//   MemRead, MemWrite   : access request from the MEM stage (both = store)
//   Funct3, addr, wdata : access width, byte address, store data
//   mem                 : memory bus (master side)
//   stall               : hold IF/ID/EX/MEM
//   rd_data             : extended load result, valid in the DONE cycle
//   fault               : 1-cycle pulse on misaligned / illegal access
//   timeout             : 1-cycle pulse when memory never acknowledged
// ---------------------------------------------------------------------------
module dmem_access_seq
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  dmem_access_seq_if.master mem,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              fault,
  output logic              timeout
);
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        f3_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              we_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] rd_reg, rd_next;

  logic latch_en, req_c, stall_c, fault_c, timeout_c;
  logic access, in_idle;

  logic [2:0]        al_f3;
  logic [1:0]        al_addr_lo;
  logic [DATA_W-1:0] al_wdata, al_lane, al_load;
  logic [3:0]        al_wmask;
  logic              al_illegal;

  assign access  = MemRead | MemWrite;
  assign in_idle = (state_reg == ST_IDLE);

  // One aligner serves both phases: in IDLE it screens the live request for
  // legality; once accepted it works on the latched fields so the bus stays
  // stable while the MEM stage inputs are free to change.
  assign al_f3      = in_idle ? Funct3    : f3_reg;
  assign al_addr_lo = in_idle ? addr[1:0] : addr_reg[1:0];
  assign al_wdata   = in_idle ? wdata     : wdata_reg;

  lsu_align u_align (
    .funct3    (al_f3),
    .addr_lo   (al_addr_lo),
    .wdata     (al_wdata),
    .rdata     (mem.mem_rdata),
    .wmask     (al_wmask),
    .lane_data (al_lane),
    .load_data (al_load),
    .illegal   (al_illegal)
  );

  // The counter is cleared on entry to REQ and also advances in REQ, so it
  // equals k during the k-th WAIT cycle; TIMEOUT WAIT cycles are allowed.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_next    = rd_reg;
    latch_en   = 1'b0;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    fault_c    = 1'b0;
    timeout_c  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (access) begin
          if (al_illegal) begin
            fault_c = 1'b1;
          end else begin
            latch_en   = 1'b1;
            stall_c    = 1'b1;
            cnt_next   = '0;
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_c    = 1'b1;
        stall_c  = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (mem.mem_ack) begin
          rd_next    = we_reg ? '0 : al_load;
          state_next = ST_DONE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        // Ack is tested first so a late ack on the limit cycle still wins.
        if (mem.mem_ack) begin
          req_c      = 1'b1;
          rd_next    = we_reg ? '0 : al_load;
          state_next = ST_DONE;
        end else if (cnt_reg == CNT_LIMIT) begin
          timeout_c  = 1'b1;
          rd_next    = '0;
          state_next = ST_DONE;
        end else begin
          req_c    = 1'b1;
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      rd_reg    <= '0;
      addr_reg  <= '0;
      f3_reg    <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rd_reg    <= rd_next;
      if (latch_en) begin
        addr_reg  <= addr;
        f3_reg    <= Funct3;
        wdata_reg <= wdata;
        we_reg    <= MemWrite;
      end
    end
  end

  assign mem.mem_req   = req_c & ~reset;
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata = al_lane;
  assign mem.mem_wmask = we_reg ? al_wmask : 4'b0000;

  assign stall   = stall_c   & ~reset;
  assign fault   = fault_c   & ~reset;
  assign timeout = timeout_c & ~reset;
  assign rd_data = (state_reg == ST_DONE) ? rd_reg : '0;
endmodule

// File: tb/tb_dmem_access_seq.sv
module tb_dmem_access_seq;
  import dmem_pkg::*;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              MemRead, MemWrite;
  logic [2:0]        Funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall, fault, timeout;
  logic [DATA_W-1:0] rd_data;

  dmem_access_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  dmem_access_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .addr     (addr),
    .wdata    (wdata),
    .mem      (mem_bus),
    .stall    (stall),
    .rd_data  (rd_data),
    .fault    (fault),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Expected observable behaviour of one clock cycle.
  typedef struct {
    bit          chk_req;
    bit          req;
    bit          stall;
    bit          fault;
    bit          timeout;
    bit          chk_bus;
    bit          we;
    logic [8:0]  maddr;
    bit          chk_st;
    logic [3:0]  wmask;
    logic [31:0] wd;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn_no   = 0;

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] bad_f3[3] = '{3'd3, 3'd6, 3'd7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_illegal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return off[0];
      3'd2:       return off != 2'd0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rw);
    logic [31:0] b, h;
    b = (rw >> (8 * off)) & 32'hFF;
    h = (rw >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      3'd2:    return rw;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] m_wmask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0:    return 4'(32'd1 << off);
      3'd1:    return 4'(32'd3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_lane(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd & 32'hFF) * 32'h01010101;
      3'd1:    return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{default: '0};
    e.chk_req = 1'b1;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(ce.stall));
      chk("fault", 32'(fault), 32'(ce.fault));
      chk("timeout", 32'(timeout), 32'(ce.timeout));
      if (ce.chk_req) chk("mem_req", 32'(mem_bus.mem_req), 32'(ce.req));
      if (ce.chk_bus) begin
        chk("mem_we", 32'(mem_bus.mem_we), 32'(ce.we));
        chk("mem_addr", 32'(mem_bus.mem_addr), 32'(ce.maddr));
      end
      if (ce.chk_st) begin
        chk("mem_wmask", 32'(mem_bus.mem_wmask), 32'(ce.wmask));
        chk("mem_wdata", mem_bus.mem_wdata, ce.wd);
      end
      if (ce.chk_rd) chk("rd_data", rd_data, ce.rd);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One MEM-stage access; lat = request cycles before ack (0 = ack in REQ).
  task automatic do_access(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                           input logic [8:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int lat);
    exp_t e;
    bit   ill, to_hit, ack_now, to_now;
    ill    = m_illegal(f3, a[1:0]);
    to_hit = 1'b0;
    MemRead  = rd_en;
    MemWrite = wr_en;
    Funct3   = f3;
    addr     = a;
    wdata    = wd;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = $urandom;
    e = idle_exp();
    e.stall = !ill;
    e.fault = ill;
    if (ill) begin
      e.chk_rd = 1'b1;
      e.rd     = 32'd0;
    end
    exp_q.push_back(e);
    next_cycle();
    if (!ill) begin
      for (int i = 0; i <= TIMEOUT; i++) begin
        ack_now = (i == lat);
        to_now  = (i == TIMEOUT) && (lat > TIMEOUT);
        mem_bus.mem_ack   = ack_now;
        mem_bus.mem_rdata = ack_now ? rw : $urandom;
        e = idle_exp();
        e.stall   = 1'b1;
        e.req     = !to_now;
        e.timeout = to_now;
        if (!to_now) begin
          e.chk_bus = 1'b1;
          e.we      = wr_en;
          e.maddr   = a & 9'h1FC;
          e.chk_st  = wr_en;
          e.wmask   = m_wmask(f3, a[1:0]);
          e.wd      = m_lane(f3, wd);
        end
        exp_q.push_back(e);
        next_cycle();
        if (ack_now || to_now) begin
          to_hit = to_now;
          break;
        end
      end
      // DONE: request inputs deliberately still held high
      mem_bus.mem_ack = 1'b0;
      e = idle_exp();
      e.chk_rd = !wr_en;
      e.rd     = to_hit ? 32'd0 : m_load(f3, a[1:0], rw);
      exp_q.push_back(e);
      next_cycle();
    end
    // gap cycle with a stray ack that the idle sequencer must ignore
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mem_bus.mem_ack = 1'($urandom_range(0, 1));
    exp_q.push_back(idle_exp());
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    txn_no++;
    $display("txn %0d: %s f3=%0d addr=0x%03h lat=%0d%s%s", txn_no,
             wr_en ? "store" : "load", f3, a, lat, ill ? " illegal" : "",
             to_hit ? " timeout" : "");
  endtask

  initial begin
    exp_t e;
    bit   rd_en, wr_en;
    logic [2:0] f3;
    int   lat;
    logic [2:0]  v_f3;
    logic [1:0]  v_off;
    logic [31:0] v_rw;

    reset = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = F3_W; addr = '0; wdata = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      e = idle_exp();
      e.chk_rd = 1'b1;
      exp_q.push_back(e);
      next_cycle();
    end
    reset = 1'b0;
    MemRead = 1'b0;
    exp_q.push_back(idle_exp());
    next_cycle();

    // model pins against hand-computed values
    v_off = 2'd3; v_rw = 32'h80FFFFFF;
    v_f3 = F3_B;  chk("pin_lb",  m_load(v_f3, v_off, v_rw), 32'hFFFFFF80);
    v_f3 = F3_BU; chk("pin_lbu", m_load(v_f3, v_off, v_rw), 32'h00000080);
    v_f3 = F3_H;  v_off = 2'd2;
    chk("pin_sh_mask", 32'(m_wmask(v_f3, v_off)), 32'h0000000C);
    v_rw = 32'h1234ABCD;
    chk("pin_sh_lane", m_lane(v_f3, v_rw), 32'hABCDABCD);
    v_f3 = F3_W;  v_off = 2'd2;
    chk("pin_lw_misaligned", 32'(m_illegal(v_f3, v_off)), 32'd1);

    // directed scenarios
    do_access(1, 0, F3_W,  9'h010, 32'h0,        32'hDEADBEEF, 0);
    do_access(1, 0, F3_B,  9'h013, 32'h0,        32'h80FFFFFF, 2);
    do_access(1, 0, F3_BU, 9'h013, 32'h0,        32'h80FFFFFF, 1);
    do_access(0, 1, F3_H,  9'h006, 32'h1234ABCD, 32'h0,        0);
    do_access(1, 0, F3_W,  9'h002, 32'h0,        32'h0,        0);
    do_access(1, 0, 3'b011, 9'h010, 32'h0,       32'h0,        0);
    do_access(0, 1, F3_W,  9'h040, 32'h55AA55AA, 32'h0,        100);
    do_access(0, 1, F3_W,  9'h044, 32'h01020304, 32'h0,        TIMEOUT);
    do_access(1, 0, F3_HU, 9'h0FE, 32'h0,        32'h8001F00F, TIMEOUT);

    // reset asserted while waiting on memory
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = F3_W; addr = 9'h020;
    mem_bus.mem_ack = 1'b0;
    e = idle_exp(); e.stall = 1'b1;
    exp_q.push_back(e);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      e = idle_exp(); e.stall = 1'b1; e.req = 1'b1;
      e.chk_bus = 1'b1; e.we = 1'b0; e.maddr = 9'h020;
      exp_q.push_back(e);
      next_cycle();
    end
    reset = 1'b1;
    e = idle_exp(); e.chk_req = 1'b0;
    exp_q.push_back(e);
    next_cycle();
    reset = 1'b0; MemRead = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
    exp_q.push_back(idle_exp());
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    exp_q.push_back(idle_exp());
    next_cycle();
    $display("txn reset-during-wait: lw addr=0x020 aborted");

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      int mode;
      mode  = int'($urandom_range(0, 3));
      rd_en = (mode != 2);
      wr_en = (mode >= 2);
      if ($urandom_range(0, 7) == 0) f3 = bad_f3[$urandom_range(0, 2)];
      else if (wr_en)                f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) lat = int'($urandom_range(13, 20));
      else                           lat = int'($urandom_range(0, 5));
      do_access(rd_en, wr_en, f3, 9'($urandom), $urandom, $urandom, lat);
    end

    next_cycle();
    next_cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1, "watchdog expired");
  end
endmodule
